uart_rx: RTL and testbench

Serial-to-parallel UART receiver. It is the receiving end of the link driven by the team's uart_tx block.
- Line: idle-high, start bit 0, WORD_LENGTH data bits LSB first, optional parity, STOP_BITS stop bits at 1.
- Samples the asynchronous line at 16x baud and presents each received word on a level-valid/ack interface to the host logic.
- Reports parity, framing and overrun errors.

---
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a level-valid/ack host interface.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority vote per bit decision.
module uart_rx #(
  parameter int    WORD_LENGTH = 8,
  parameter string PARITY      = "none",
  parameter int    STOP_BITS   = 1,
  parameter int    BAUD_RATE   = 9600,
  parameter int    CLK_FREQ    = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic                   rx_ack,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   rx_busy
);
  localparam logic [31:0] DIV       = 32'(CLK_FREQ / (BAUD_RATE * 16) - 1);
  localparam bit          PAR_EN    = (PARITY != "none");
  localparam bit          PAR_ODD   = (PARITY == "odd");
  localparam logic [3:0]  LAST_DATA = 4'(WORD_LENGTH - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q, prev_q;
  logic [31:0]            cnt_q, cnt_d;
  logic [3:0]             samp_q, samp_d, bit_q, bit_d;
  logic [WORD_LENGTH-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                   pflag_q, pflag_d, fflag_q, fflag_d;
  logic                   valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
  logic                   tick, fall, bit_ev, bit_val, commit, exp_par;

  assign tick    = (cnt_q == DIV);
  assign fall    = prev_q & ~sync2_q;
  assign exp_par = PAR_ODD ? ~^shreg_q : ^shreg_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Samples at a and b are held; the decision is taken at c using the live sample.
  logic       v0_q, v0_d, v1_q, v1_d, arm_q, arm_d;
  logic [3:0] pt_a, pt_b, pt_c;

  always_comb begin
    pt_a   = (state_q == S_START) ? 4'd6 : 4'd14;
    pt_b   = (state_q == S_START) ? 4'd7 : 4'd15;
    pt_c   = (state_q == S_START) ? 4'd8 : 4'd0;
    v0_d   = v0_q;
    v1_d   = v1_q;
    arm_d  = arm_q;
    bit_ev = 1'b0;
    if (tick && state_q != S_IDLE) begin
      if (samp_q == pt_a) v0_d = sync2_q;
      if (samp_q == pt_b) begin
        v1_d  = sync2_q;
        arm_d = 1'b1;
      end
      if (samp_q == pt_c && arm_q) begin
        bit_ev = 1'b1;
        arm_d  = 1'b0;
      end
    end
    if (state_q == S_IDLE) arm_d = 1'b0;
  end

  assign bit_val = (v0_q & v1_q) | (v0_q & sync2_q) | (v1_q & sync2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q  <= 1'b1;
      v1_q  <= 1'b1;
      arm_q <= 1'b0;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      arm_q <= arm_d;
    end
  end
`else
  assign bit_ev  = tick && (samp_q == ((state_q == S_START) ? 4'd7 : 4'd15));
  assign bit_val = sync2_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 32'd1;
    samp_d  = tick ? samp_q + 4'd1 : samp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pflag_d = pflag_q;
    fflag_d = fflag_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (fall) begin
        state_d = S_START;
        cnt_d   = '0;
        samp_d  = '0;
        pflag_d = 1'b0;
        fflag_d = 1'b0;
      end
      S_START: if (bit_ev) begin
        if (!bit_val) begin
          state_d = S_DATA;
          samp_d  = '0;
          bit_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: if (bit_ev) begin
        shreg_d = {bit_val, shreg_q[WORD_LENGTH-1:1]};
        bit_d   = bit_q + 4'd1;
        if (bit_q == LAST_DATA) begin
          bit_d   = '0;
          state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_ev) begin
        pflag_d = (bit_val != exp_par);
        state_d = S_STOP;
      end
      S_STOP: if (bit_ev) begin
        if (!bit_val) fflag_d = 1'b1;
        bit_d = bit_q + 4'd1;
        // Leave mid-stop so a back-to-back start edge is not missed.
        if (bit_q == LAST_STOP) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    oerr_d  = oerr_q;
    if (commit) begin
      data_d  = shreg_q;
      perr_d  = pflag_q;
      ferr_d  = fflag_q | ~bit_val;
      oerr_d  = valid_q & ~rx_ack;
      valid_d = 1'b1;
    end else if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      oerr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pflag_q <= 1'b0;
      fflag_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pflag_q <= pflag_d;
      fflag_q <= fflag_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;
  assign rx_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (no parity, even parity) at 16 clk/bit, checked each
// cycle against a frame-level timing model plus literal expectations.
module tb_uart_rx;
  localparam int CLKF = 16_000_000;
  localparam int BAUD = 1_000_000;

  typedef struct {
    int         t_on;
    int         t_off;
    bit         commit;
    logic [7:0] data;
    bit         perr;
    bit         ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, rxn, rxe, ackn, acke;
  logic [7:0] dn, de;
  logic       vn, ve, pn, pe, fn, fe, on_, oe, bn, be;
  int         cyc = 0;
  int         checks = 0, failures = 0;
  bit         auto_n, auto_e;
  int         ack_edge_n, ack_edge_e;
  exp_t       qn[$], qe[$];

  logic [7:0] m_data [2];
  bit         m_valid [2], m_perr [2], m_ferr [2], m_oerr [2], m_busy [2];
  int         me;
  bit         mhas, mdone;
  logic       ma;
  exp_t       mf;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.WORD_LENGTH(8), .PARITY("none"), .STOP_BITS(1), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) u_n (
    .clk(clk), .rst(rst), .rx_in(rxn), .rx_ack(ackn), .rx_data(dn), .rx_valid(vn),
    .parity_err(pn), .frame_err(fn), .overrun_err(on_), .rx_busy(bn));

  uart_rx #(.WORD_LENGTH(8), .PARITY("even"), .STOP_BITS(1), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) u_e (
    .clk(clk), .rst(rst), .rx_in(rxe), .rx_ack(acke), .rx_data(de), .rx_valid(ve),
    .parity_err(pe), .frame_err(fe), .overrun_err(oe), .rx_busy(be));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: busy from 3 clk after the line falls (sync + edge detect) until the
  // last stop mid-bit, commit on that edge (start mid at +11, then 16 clk per bit).
  always @(posedge clk) begin
    me = cyc + 1;
    if (rst) begin
      qn.delete();
      qe.delete();
      for (int w = 0; w < 2; w++) begin
        m_data[w] <= '0; m_valid[w] <= 0; m_perr[w] <= 0;
        m_ferr[w] <= 0;  m_oerr[w] <= 0;  m_busy[w] <= 0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        mhas  = 0;
        mdone = 0;
        ma    = (w == 0) ? ackn : acke;
        if (w == 0 && qn.size() > 0) begin mf = qn[0]; mhas = 1; end
        if (w == 1 && qe.size() > 0) begin mf = qe[0]; mhas = 1; end
        if (mhas && me == mf.t_on) m_busy[w] <= 1;
        if (mhas && me == mf.t_off) begin
          m_busy[w] <= 0;
          mdone = 1;
        end
        if (mdone && mf.commit) begin
          m_data[w]  <= mf.data;
          m_perr[w]  <= mf.perr;
          m_ferr[w]  <= mf.ferr;
          m_oerr[w]  <= m_valid[w] & ~ma;
          m_valid[w] <= 1;
        end else if (ma && m_valid[w]) begin
          m_valid[w] <= 0; m_perr[w] <= 0; m_ferr[w] <= 0; m_oerr[w] <= 0;
        end
        if (mdone && w == 0) void'(qn.pop_front());
        if (mdone && w == 1) void'(qe.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    ackn = auto_n ? vn : (cyc + 1 == ack_edge_n);
    acke = auto_e ? ve : (cyc + 1 == ack_edge_e);
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("n.rx_valid", vn, m_valid[0]);  chk("n.rx_data", dn, m_data[0]);
      chk("n.parity_err", pn, m_perr[0]); chk("n.frame_err", fn, m_ferr[0]);
      chk("n.overrun_err", on_, m_oerr[0]); chk("n.rx_busy", bn, m_busy[0]);
      chk("e.rx_valid", ve, m_valid[1]);  chk("e.rx_data", de, m_data[1]);
      chk("e.parity_err", pe, m_perr[1]); chk("e.frame_err", fe, m_ferr[1]);
      chk("e.overrun_err", oe, m_oerr[1]); chk("e.rx_busy", be, m_busy[1]);
    end
  end

  task automatic drive_bit(input bit which, input logic v, input int n);
    if (which) rxe = v; else rxn = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxn = 1'b1;
    rxe = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // par: -1 = no parity bit, else the parity bit value put on the line.
  task automatic send_frame(input bit which, input logic [7:0] d, input int par,
                            input logic stop_v, input int abort_bit);
    exp_t x;
    int   nb;
    nb       = 8 + ((par >= 0) ? 1 : 0) + 1;
    x.t_on   = cyc + 3;
    x.t_off  = cyc + 11 + 16 * nb;
    x.commit = 1;
    x.data   = d;
    x.perr   = (par >= 0) && ((par == 1) != (^d));
    x.ferr   = ~stop_v;
    if (which) qe.push_back(x); else qn.push_back(x);
    drive_bit(which, 1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        drive_bit(which, d[i], 8);
        rst = 1'b1;
        rxn = 1'b1;
        rxe = 1'b1;
        drive_bit(which, 1'b1, 1);
        rst = 1'b0;
        return;
      end
      drive_bit(which, d[i], 16);
    end
    if (par >= 0) drive_bit(which, (par == 1), 16);
    drive_bit(which, stop_v, 16);
  endtask

  task automatic glitch();
    exp_t x;
    x.t_on = cyc + 3; x.t_off = cyc + 11; x.commit = 0;
    x.data = '0; x.perr = 0; x.ferr = 0;
    qn.push_back(x);
    drive_bit(0, 1'b0, 4);
    chk("glitch.busy_high", bn, 1);
    drive_bit(0, 1'b1, 20);
    chk("glitch.busy_low", bn, 0);
    chk("glitch.no_valid", vn, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rxn = 1'b1; rxe = 1'b1; ackn = 1'b0; acke = 1'b0;
    auto_n = 0; auto_e = 0; ack_edge_n = -1; ack_edge_e = -1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.rx_valid", vn, 0); chk("reset.rx_data", dn, 0);
    chk("reset.rx_busy", bn, 0);  chk("reset.errs", {pn, fn, on_}, 0);
    idle(10);

    send_frame(0, 8'hA5, -1, 1'b1, -1);
    chk("basic.rx_data", dn, 8'hA5); chk("basic.rx_valid", vn, 1);
    chk("basic.errs", {pn, fn, on_}, 0);
    ack_edge_n = cyc + 1;
    idle(1);
    chk("basic.ack_clears", vn, 0);
    idle(10);

    auto_n = 1;
    send_frame(0, 8'h00, -1, 1'b1, -1);
    chk("b2b.first", dn, 8'h00);  chk("b2b.first_acked", vn, 0);
    send_frame(0, 8'hFF, -1, 1'b1, -1);
    chk("b2b.second", dn, 8'hFF); chk("b2b.second_acked", vn, 0);
    send_frame(0, 8'h3C, -1, 1'b1, -1);
    chk("b2b.third", dn, 8'h3C);  chk("b2b.errs", {pn, fn, on_}, 0);
    idle(4);
    auto_n = 0;
    idle(10);

    glitch();
    idle(10);

    send_frame(1, 8'h01, 0, 1'b1, -1);
    chk("par.perr", pe, 1); chk("par.data", de, 8'h01); chk("par.ferr", fe, 0);
    ack_edge_e = cyc + 1;
    idle(1);
    chk("par.ack_clears", pe, 0);
    idle(10);
    send_frame(1, 8'h07, 1, 1'b1, -1);
    chk("par.good_perr", pe, 0); chk("par.good_data", de, 8'h07);
    ack_edge_e = cyc + 1;
    idle(10);
    send_frame(1, 8'h55, 0, 1'b0, -1);
    idle(4);
    chk("frm.ferr", fe, 1); chk("frm.data", de, 8'h55); chk("frm.perr", pe, 0);
    ack_edge_e = cyc + 1;
    idle(10);

    send_frame(0, 8'h00, -1, 1'b0, -1);
    drive_bit(0, 1'b0, 100);
    idle(10);
    chk("break.ferr", fn, 1); chk("break.data", dn, 8'h00); chk("break.valid", vn, 1);
    ack_edge_n = cyc + 1;
    idle(10);

    send_frame(0, 8'h11, -1, 1'b1, -1);
    send_frame(0, 8'h22, -1, 1'b1, -1);
    chk("ovr.data", dn, 8'h22); chk("ovr.oerr", on_, 1); chk("ovr.valid", vn, 1);
    ack_edge_n = cyc + 1;
    idle(1);
    chk("ovr.ack_clears", on_, 0);
    idle(10);
    send_frame(0, 8'h33, -1, 1'b1, -1);
    ack_edge_n = cyc + 155;
    send_frame(0, 8'h44, -1, 1'b1, -1);
    chk("ovr.same_clk_data", dn, 8'h44); chk("ovr.same_clk_valid", vn, 1);
    chk("ovr.same_clk_oerr", on_, 0);
    ack_edge_n = cyc + 1;
    idle(10);

    send_frame(0, 8'h99, -1, 1'b1, 4);
    chk("rst.rx_data", dn, 0); chk("rst.rx_valid", vn, 0);
    chk("rst.rx_busy", bn, 0); chk("rst.errs", {pn, fn, on_}, 0);
    idle(20);
    send_frame(0, 8'h66, -1, 1'b1, -1);
    chk("rst.clean_data", dn, 8'h66); chk("rst.clean_valid", vn, 1);
    chk("rst.clean_errs", {pn, fn, on_}, 0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
